// File: rtl/regnet_sequencer_if.sv
// Bundles the host-side load/start/result port and the regnet-side chunk/label
// port of regnet_sequencer into one interface.
interface regnet_sequencer_if #(
  parameter int NUM_PIXELS  = 10,
  parameter int INPUT_SIZE  = 1,
  parameter int NUM_CLASSES = 10,
  parameter int PIXEL_W     = 16,
  parameter int COUNT_WIDTH = 16
);
  localparam int ADDR_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int LABEL_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                                load_valid;
  logic [ADDR_W-1:0]                   load_address;
  logic signed [PIXEL_W-1:0]           load_pixel;
  logic                                load_ready;
  logic                                start;
  logic                                busy;
  logic                                image_ready;
  logic [INPUT_SIZE-1:0][PIXEL_W-1:0]  pixels;
  logic                                label_ready;
  logic [LABEL_W-1:0]                  label;
  logic                                result_valid;
  logic [LABEL_W-1:0]                  result_label;
  logic                                result_error;
  logic [COUNT_WIDTH-1:0]              result_cycles;
  logic                                result_ack;

  modport master (
    output load_valid, load_address, load_pixel, start, label_ready, label, result_ack,
    input  load_ready, busy, image_ready, pixels, result_valid, result_label,
           result_error, result_cycles
  );

  modport slave (
    input  load_valid, load_address, load_pixel, start, label_ready, label, result_ack,
    output load_ready, busy, image_ready, pixels, result_valid, result_label,
           result_error, result_cycles
  );
endinterface

// File: rtl/regnet_sequencer.sv
// Inference controller for regnet: buffers one image, streams it in chunks,
// waits for the label under a watchdog and holds the result until acknowledged.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | buffer writable, waiting for start
//   ST_STREAM | one chunk per cycle on pixels with image_ready high
//   ST_WAIT   | waiting for label_ready, watchdog counting down
//   ST_DONE   | result held until result_ack
module regnet_sequencer #(
  parameter int NUM_PIXELS     = 10,
  parameter int INPUT_SIZE     = 1,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  regnet_sequencer_if.slave bus
);
  localparam int PIXEL_W    = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int ADDR_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int NUM_CHUNKS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_W:0]    PIX_LIMIT  = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic [WD_W-1:0]    WD_LOAD    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_WAIT, ST_DONE} state_t;

  state_t                             state;
  logic [PIXEL_W-1:0]                 pix_buf [NUM_PIXELS];
  logic [CHUNK_W-1:0]                 chunk_idx;
  logic [CHUNK_W-1:0]                 load_chunk;
  logic [WD_W-1:0]                    wd_cnt;
  logic                               write_en;
  logic [INPUT_SIZE-1:0][PIXEL_W-1:0] chunk_data;
  logic [COUNT_WIDTH-1:0]             cycles_next;
  int                                 lane_pos;
  logic [ADDR_W-1:0]                  pix_idx;

  assign write_en    = (state == ST_IDLE) && bus.load_valid &&
                       ({1'b0, bus.load_address} < PIX_LIMIT);
  assign load_chunk  = (state == ST_STREAM) ? chunk_idx + 1'b1 : '0;
  assign cycles_next = (&bus.result_cycles) ? bus.result_cycles
                                            : bus.result_cycles + 1'b1;

  // Buffer is deliberately left out of reset so an image survives a reset.
  always_ff @(posedge clock) begin
    if (write_en) pix_buf[bus.load_address] <= bus.load_pixel;
  end

  // Chunk for the next edge; a same-cycle write is forwarded so it streams.
  always_comb begin
    chunk_data = '0;
    lane_pos   = 0;
    pix_idx    = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      lane_pos = int'(load_chunk) * INPUT_SIZE + i;
      pix_idx  = ADDR_W'(lane_pos);
      if (lane_pos < NUM_PIXELS) begin
        if (write_en && (bus.load_address == pix_idx))
          chunk_data[i] = bus.load_pixel;
        else
          chunk_data[i] = pix_buf[pix_idx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      chunk_idx         <= '0;
      wd_cnt            <= '0;
      bus.load_ready    <= 1'b1;
      bus.busy          <= 1'b0;
      bus.image_ready   <= 1'b0;
      bus.pixels        <= '0;
      bus.result_valid  <= 1'b0;
      bus.result_label  <= '0;
      bus.result_error  <= 1'b0;
      bus.result_cycles <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state             <= ST_STREAM;
            chunk_idx         <= '0;
            bus.load_ready    <= 1'b0;
            bus.busy          <= 1'b1;
            bus.image_ready   <= 1'b1;
            bus.pixels        <= chunk_data;
            bus.result_cycles <= '0;
          end
        end
        ST_STREAM: begin
          bus.result_cycles <= cycles_next;
          if (chunk_idx == LAST_CHUNK) begin
            state           <= ST_WAIT;
            wd_cnt          <= WD_LOAD;
            bus.image_ready <= 1'b0;
            bus.pixels      <= '0;
          end else begin
            chunk_idx  <= chunk_idx + 1'b1;
            bus.pixels <= chunk_data;
          end
        end
        ST_WAIT: begin
          bus.result_cycles <= cycles_next;
          // A label on the expiry cycle takes priority over the watchdog.
          if (bus.label_ready) begin
            state            <= ST_DONE;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result_label <= bus.label;
            bus.result_error <= 1'b0;
          end else if (wd_cnt == '0) begin
            state            <= ST_DONE;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result_label <= '0;
            bus.result_error <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.result_ack) begin
            state            <= ST_IDLE;
            bus.result_valid <= 1'b0;
            bus.load_ready   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regnet_sequencer.sv
// Bench for regnet_sequencer: two instances (1-lane and 3-lane) checked every
// cycle against a phase-level model, plus hand-computed literal expectations.
module tb_regnet_sequencer;
  localparam int NPIX  = 10;
  localparam int ISZ_A = 1;
  localparam int ISZ_B = 3;
  localparam int TMO_A = 20;
  localparam int TMO_B = 1024;
  localparam int ONE   = 256;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  regnet_sequencer_if #(.INPUT_SIZE(ISZ_A)) ifa ();
  regnet_sequencer_if #(.INPUT_SIZE(ISZ_B)) ifb ();

  regnet_sequencer #(.INPUT_SIZE(ISZ_A), .TIMEOUT_CYCLES(TMO_A)) dut_a (
    .clock(clock), .reset(rst_n), .bus(ifa.slave));
  regnet_sequencer #(.INPUT_SIZE(ISZ_B), .TIMEOUT_CYCLES(TMO_B)) dut_b (
    .clock(clock), .reset(rst_n), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int qa[$];
  int qb[$];
  int base;

  // Model: phase 0 idle, 1 streaming, 2 waiting, 3 holding a result.
  int m_phase  [2];
  int m_chunk  [2];
  int m_waited [2];
  int m_cycles [2];
  int m_lbl    [2];
  bit m_err    [2];
  int m_img    [2][NPIX];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic m_reset(input int d);
    m_phase[d] = 0; m_chunk[d] = 0; m_waited[d] = 0;
    m_cycles[d] = 0; m_lbl[d] = 0; m_err[d] = 1'b0;
  endtask

  task automatic m_step(input int d, input bit lv, input int addr, input int pix,
                        input bit st, input bit lr, input int lb, input bit ack,
                        input int isz, input int tmo);
    int nchunks;
    nchunks = (NPIX + isz - 1) / isz;
    case (m_phase[d])
      0: begin
        if (lv && addr < NPIX) m_img[d][addr] = pix;
        if (st) begin m_phase[d] = 1; m_chunk[d] = 0; m_cycles[d] = 0; end
      end
      1: begin
        m_cycles[d] = sat(m_cycles[d]);
        if (m_chunk[d] == nchunks - 1) begin m_phase[d] = 2; m_waited[d] = 0; end
        else m_chunk[d] = m_chunk[d] + 1;
      end
      2: begin
        m_cycles[d] = sat(m_cycles[d]);
        m_waited[d] = m_waited[d] + 1;
        if (lr) begin m_phase[d] = 3; m_lbl[d] = lb; m_err[d] = 1'b0; end
        else if (m_waited[d] == tmo) begin m_phase[d] = 3; m_lbl[d] = 0; m_err[d] = 1'b1; end
      end
      default: if (ack) m_phase[d] = 0;
    endcase
  endtask

  function automatic int exp_pix(input int d, input int isz, input int lane);
    int idx;
    idx = m_chunk[d] * isz + lane;
    if (m_phase[d] == 1 && idx < NPIX) return m_img[d][idx];
    return 0;
  endfunction

  initial for (int d = 0; d < 2; d++) for (int i = 0; i < NPIX; i++) m_img[d][i] = 0;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, ifa.load_valid, int'(ifa.load_address), int'($signed(ifa.load_pixel)),
             ifa.start, ifa.label_ready, int'(ifa.label), ifa.result_ack, ISZ_A, TMO_A);
      m_step(1, ifb.load_valid, int'(ifb.load_address), int'($signed(ifb.load_pixel)),
             ifb.start, ifb.label_ready, int'(ifb.label), ifb.result_ack, ISZ_B, TMO_B);
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("a_image_ready",   ifa.image_ready,   m_phase[0] == 1);
      chk("a_busy",          ifa.busy,          m_phase[0] == 1 || m_phase[0] == 2);
      chk("a_load_ready",    ifa.load_ready,    m_phase[0] == 0);
      chk("a_result_valid",  ifa.result_valid,  m_phase[0] == 3);
      chk("a_result_label",  ifa.result_label,  m_lbl[0]);
      chk("a_result_error",  ifa.result_error,  m_err[0]);
      chk("a_result_cycles", ifa.result_cycles, m_cycles[0]);
      chk("a_pixels",        int'($signed(ifa.pixels[0])), exp_pix(0, ISZ_A, 0));
      chk("b_image_ready",   ifb.image_ready,   m_phase[1] == 1);
      chk("b_busy",          ifb.busy,          m_phase[1] == 1 || m_phase[1] == 2);
      chk("b_load_ready",    ifb.load_ready,    m_phase[1] == 0);
      chk("b_result_valid",  ifb.result_valid,  m_phase[1] == 3);
      chk("b_result_label",  ifb.result_label,  m_lbl[1]);
      chk("b_result_error",  ifb.result_error,  m_err[1]);
      chk("b_result_cycles", ifb.result_cycles, m_cycles[1]);
      for (int i = 0; i < ISZ_B; i++)
        chk("b_pixels", int'($signed(ifb.pixels[i])), exp_pix(1, ISZ_B, i));
    end
    if (ifa.image_ready) qa.push_back(int'($signed(ifa.pixels[0])));
    if (ifb.image_ready)
      for (int i = 0; i < ISZ_B; i++) qb.push_back(int'($signed(ifb.pixels[i])));
  end

  task automatic drv_a(input bit lv, input int addr, input int pix, input bit st,
                       input bit lr, input int lb, input bit ack);
    ifa.load_valid = lv; ifa.load_address = addr[3:0]; ifa.load_pixel = pix[15:0];
    ifa.start = st; ifa.label_ready = lr; ifa.label = lb[3:0]; ifa.result_ack = ack;
    @(negedge clock);
    ifa.load_valid = 0; ifa.load_address = '0; ifa.load_pixel = '0;
    ifa.start = 0; ifa.label_ready = 0; ifa.label = '0; ifa.result_ack = 0;
  endtask

  task automatic drv_b(input bit lv, input int addr, input int pix, input bit st,
                       input bit lr, input int lb, input bit ack);
    ifb.load_valid = lv; ifb.load_address = addr[3:0]; ifb.load_pixel = pix[15:0];
    ifb.start = st; ifb.label_ready = lr; ifb.label = lb[3:0]; ifb.result_ack = ack;
    @(negedge clock);
    ifb.load_valid = 0; ifb.load_address = '0; ifb.load_pixel = '0;
    ifb.start = 0; ifb.label_ready = 0; ifb.label = '0; ifb.result_ack = 0;
  endtask

  task automatic idle_a(input int n);
    repeat (n) drv_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_b(input int n);
    repeat (n) drv_b(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    ifa.load_valid = 0; ifa.load_address = '0; ifa.load_pixel = '0; ifa.start = 0;
    ifa.label_ready = 0; ifa.label = '0; ifa.result_ack = 0;
    ifb.load_valid = 0; ifb.load_address = '0; ifb.load_pixel = '0; ifb.start = 0;
    ifb.label_ready = 0; ifb.label = '0; ifb.result_ack = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    cmp_on = 1'b1;
    chk("reset_load_ready",   ifa.load_ready,    1);
    chk("reset_busy",         ifa.busy,          0);
    chk("reset_image_ready",  ifa.image_ready,   0);
    chk("reset_result_valid", ifa.result_valid,  0);
    chk("reset_cycles",       ifa.result_cycles, 0);
    rst_n = 1'b1;
    idle_a(1);

    // 1: ten single-pixel chunks, label 7 on the 5th WAIT cycle
    for (int i = 0; i < NPIX; i++) drv_a(1, i, i * ONE, 0, 0, 0, 0);
    drv_a(1, 12, 77 * ONE, 0, 0, 0, 0);
    base = qa.size();
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(14);
    drv_a(0, 0, 0, 0, 1, 7, 0);
    chk("t1_stream_len", qa.size() - base, 10);
    for (int k = 0; k < NPIX; k++)
      if (base + k < qa.size()) chk("t1_pixel", qa[base + k], k * ONE);
    chk("t1_result_valid", ifa.result_valid, 1);
    chk("t1_result_label", ifa.result_label, 7);
    chk("t1_result_error", ifa.result_error, 0);
    chk("t1_result_cycles", ifa.result_cycles, 15);
    drv_a(0, 0, 0, 0, 0, 0, 1);
    chk("t1_ack_load_ready", ifa.load_ready, 1);
    chk("t1_ack_valid", ifa.result_valid, 0);
    chk("t1_ack_label_held", ifa.result_label, 7);

    // 2: three lanes, four chunks with zero fill
    for (int i = 0; i < NPIX; i++) drv_b(1, i, i * ONE, 0, 0, 0, 0);
    base = qb.size();
    drv_b(0, 0, 0, 1, 0, 0, 0);
    idle_b(5);
    drv_b(0, 0, 0, 0, 1, 3, 0);
    chk("t2_stream_len", qb.size() - base, 12);
    begin
      int exp_b [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
      for (int k = 0; k < 12; k++)
        if (base + k < qb.size()) chk("t2_lane_value", qb[base + k], exp_b[k] * ONE);
    end
    chk("t2_result_label", ifb.result_label, 3);
    chk("t2_result_cycles", ifb.result_cycles, 6);
    drv_b(0, 0, 0, 0, 0, 0, 1);

    // 3: watchdog expiry
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(30);
    chk("t3_result_valid", ifa.result_valid, 1);
    chk("t3_result_error", ifa.result_error, 1);
    chk("t3_result_label", ifa.result_label, 0);
    chk("t3_result_cycles", ifa.result_cycles, 30);
    drv_a(0, 0, 0, 0, 0, 0, 1);
    chk("t3_load_ready", ifa.load_ready, 1);

    // 4: start and load during STREAM are ignored
    base = qa.size();
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(2);
    drv_a(1, 3, 99 * ONE, 1, 0, 0, 0);
    idle_a(7);
    drv_a(0, 0, 0, 0, 1, 2, 0);
    chk("t4_result_cycles", ifa.result_cycles, 11);
    chk("t4_result_label", ifa.result_label, 2);
    drv_a(0, 0, 0, 0, 0, 0, 1);
    idle_a(1);
    base = qa.size();
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(10);
    if (base + 3 < qa.size()) chk("t4_buffer3_kept", qa[base + 3], 3 * ONE);
    else chk("t4_stream_len", qa.size() - base, 10);
    drv_a(0, 0, 0, 0, 1, 5, 0);
    drv_a(0, 0, 0, 0, 0, 0, 1);

    // 5: async reset on the 4th STREAM cycle
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_reset_image_ready", ifa.image_ready, 0);
    chk("t5_reset_busy", ifa.busy, 0);
    chk("t5_reset_load_ready", ifa.load_ready, 1);
    @(negedge clock);
    rst_n = 1'b1;
    idle_a(1);
    chk("t5_idle_load_ready", ifa.load_ready, 1);
    base = qa.size();
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(10);
    chk("t5_stream_len", qa.size() - base, 10);
    for (int k = 0; k < NPIX; k++)
      if (base + k < qa.size()) chk("t5_pixel", qa[base + k], k * ONE);
    drv_a(0, 0, 0, 0, 1, 1, 0);
    drv_a(0, 0, 0, 0, 0, 0, 1);

    // 6: label on the expiry cycle wins
    drv_a(0, 0, 0, 1, 0, 0, 0);
    idle_a(29);
    drv_a(0, 0, 0, 0, 1, 4, 0);
    chk("t6_result_label", ifa.result_label, 4);
    chk("t6_result_error", ifa.result_error, 0);
    chk("t6_result_cycles", ifa.result_cycles, 30);
    drv_a(0, 0, 0, 0, 0, 0, 1);
    idle_a(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
